// File: rtl/mips_cpu_pkg.sv
// -----------------------------------------------------------------------------
// mips_cpu_pkg
//   Shared types for the MIPS core multiply/divide unit and the decoder.
//   muldiv_op_t    : 3-bit operation code issued to the HI/LO unit.
//   muldiv_state_t : control FSM states of the multiply/divide unit.
// -----------------------------------------------------------------------------
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        MULDIV_OP_NONE  = 3'd0,
        MULDIV_OP_MULT  = 3'd1,
        MULDIV_OP_MULTU = 3'd2,
        MULDIV_OP_DIV   = 3'd3,
        MULDIV_OP_DIVU  = 3'd4,
        MULDIV_OP_MTHI  = 3'd5,
        MULDIV_OP_MTLO  = 3'd6
    } muldiv_op_t;

    typedef enum logic [1:0] {
        MULDIV_ST_IDLE = 2'd0,
        MULDIV_ST_MUL  = 2'd1,
        MULDIV_ST_DIV  = 2'd2,
        MULDIV_ST_FIX  = 2'd3
    } muldiv_state_t;

    // Signed variants iterate on operand magnitudes and need a sign fix-up.
    function automatic logic muldiv_op_is_signed(input muldiv_op_t op);
        return (op == MULDIV_OP_MULT) || (op == MULDIV_OP_DIV);
    endfunction

endpackage

// File: rtl/mips_cpu_muldiv_core_iter.sv
// -----------------------------------------------------------------------------
// mips_cpu_muldiv_core_iter
//   Iterative unsigned datapath: one shift-add multiply step or one restoring
//   divide step per enabled clock, plus the iteration counter.
//   Multiply: acc_hi accumulates, acc_lo holds the multiplier and shifts the
//             low product bits in; after WIDTH steps {acc_hi,acc_lo} = a*b.
//   Divide:   acc_hi is the partial remainder, acc_lo shifts the dividend out
//             and the quotient bits in; after WIDTH steps acc_lo = a/b,
//             acc_hi = a%b.
// Ports
//   clk_i, reset_i  clock, synchronous active-high reset
//   en_i            clock enable; nothing changes while low
//   load_i          start a new operation with a_mag_i / b_mag_i
//   mode_div_i      operation kind captured at load (1 = divide)
//   step_i          perform one iteration
//   acc_hi_o/lo_o   accumulator halves (result once last step done)
//   last_o          the current step is the final (WIDTH-th) one
// -----------------------------------------------------------------------------
module mips_cpu_muldiv_core_iter
    import mips_cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic             mode_div_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_mag_i,
    input  logic [WIDTH-1:0] b_mag_i,
    output logic [WIDTH-1:0] acc_hi_o,
    output logic [WIDTH-1:0] acc_lo_o,
    output logic             last_o
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic [WIDTH-1:0] operand_q;
    logic [CNT_W-1:0] count_q;
    logic             mode_div_q;

    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   rem_shift_s;
    logic             div_ge_s;
    logic [WIDTH-1:0] div_rem_s;

    // One iteration of the shift-add multiplier and the restoring divider.
    always_comb begin
        mul_sum_s   = {1'b0, acc_hi_q} + ({1'b0, operand_q} & {(WIDTH+1){acc_lo_q[0]}});
        rem_shift_s = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ge_s    = (rem_shift_s >= {1'b0, operand_q});
        // When the trial subtraction succeeds the result is below the divisor,
        // so a WIDTH-bit difference is exact.
        div_rem_s   = rem_shift_s[WIDTH-1:0] - operand_q;
    end

    // Accumulator, operand and counter registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_hi_q   <= {WIDTH{1'b0}};
            acc_lo_q   <= {WIDTH{1'b0}};
            operand_q  <= {WIDTH{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            mode_div_q <= 1'b0;
        end else if (en_i) begin
            if (load_i) begin
                acc_hi_q   <= {WIDTH{1'b0}};
                acc_lo_q   <= a_mag_i;
                operand_q  <= b_mag_i;
                count_q    <= {CNT_W{1'b0}};
                mode_div_q <= mode_div_i;
            end else if (step_i) begin
                count_q <= count_q + CNT_W'(1);
                if (mode_div_q) begin
                    acc_hi_q <= div_ge_s ? div_rem_s : rem_shift_s[WIDTH-1:0];
                    acc_lo_q <= {acc_lo_q[WIDTH-2:0], div_ge_s};
                end else begin
                    acc_hi_q <= mul_sum_s[WIDTH:1];
                    acc_lo_q <= {mul_sum_s[0], acc_lo_q[WIDTH-1:1]};
                end
            end
        end
    end

    assign acc_hi_o = acc_hi_q;
    assign acc_lo_o = acc_lo_q;
    assign last_o   = (count_q == CNT_W'(WIDTH-1));

endmodule

// File: rtl/mips_cpu_muldiv_unit.sv
// -----------------------------------------------------------------------------
// mips_cpu_muldiv_unit
//   Multi-cycle HI/LO multiply/divide unit. Owns architectural HI and LO,
//   accepts operations through a valid/ready handshake and runs MULT/MULTU/
//   DIV/DIVU on the iterative datapath (mips_cpu_muldiv_core_iter), applying
//   the sign fix-up for signed operations in the FIX state.
// Ports
//   clk_i, reset_i   clock, synchronous active-high reset
//   clk_enable_i     all state advances only when high
//   op_valid_i       operation request; op_ready_o = !busy
//   op_i             muldiv_op_t operation code
//   op_a_i, op_b_i   Rs / Rt operands, latched at accept
//   busy_o           iterative operation in flight
//   done_o           one-cycle pulse after MULT/DIV updated HI/LO
//   hi_o, lo_o       architectural HI / LO
// Configuration
//   MIPS_MULDIV_FAST_MULT_EN: when defined, MULT/MULTU complete with a single
//   cycle multiplier (HI/LO written at accept, done the following cycle,
//   busy never raised). DIV/DIVU are iterative in both builds.
// -----------------------------------------------------------------------------
module mips_cpu_muldiv_unit
    import mips_cpu_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = '1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clk_enable_i,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  muldiv_op_t       op_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    muldiv_state_t    state_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;
    logic             is_div_q;
    logic             div0_q;
    logic             prod_neg_q;
    logic             quo_neg_q;
    logic             rem_neg_q;
    logic [WIDTH-1:0] a_raw_q;

    logic             accept_s;
    logic             signed_op_s;
    logic             a_neg_s;
    logic             b_neg_s;
    logic             b_zero_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic             is_mul_op_s;
    logic             is_div_op_s;
    logic             core_load_s;
    logic             core_step_s;
    logic             core_last_s;
    logic [WIDTH-1:0] core_hi_s;
    logic [WIDTH-1:0] core_lo_s;

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   quo_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;

`ifdef MIPS_MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_a_s;
    logic [2*WIDTH-1:0] fast_b_s;
    logic [2*WIDTH-1:0] fast_prod_s;

    // Single-cycle product; the low 2*WIDTH bits of the sign-extended product
    // are the two's complement result for MULT.
    always_comb begin
        if (op_i == MULDIV_OP_MULT) begin
            fast_a_s = {{WIDTH{op_a_i[WIDTH-1]}}, op_a_i};
            fast_b_s = {{WIDTH{op_b_i[WIDTH-1]}}, op_b_i};
        end else begin
            fast_a_s = {{WIDTH{1'b0}}, op_a_i};
            fast_b_s = {{WIDTH{1'b0}}, op_b_i};
        end
        fast_prod_s = $unsigned(fast_a_s) * $unsigned(fast_b_s);
    end
`endif

    // Handshake decode and operand magnitudes for the iterative datapath.
    always_comb begin
        accept_s    = op_valid_i & ~busy_q & clk_enable_i;
        signed_op_s = muldiv_op_is_signed(op_i);
        a_neg_s     = signed_op_s & op_a_i[WIDTH-1];
        b_neg_s     = signed_op_s & op_b_i[WIDTH-1];
        b_zero_s    = (op_b_i == {WIDTH{1'b0}});
        a_mag_s     = a_neg_s ? (~op_a_i + WIDTH'(1)) : op_a_i;
        b_mag_s     = b_neg_s ? (~op_b_i + WIDTH'(1)) : op_b_i;
        is_mul_op_s = (op_i == MULDIV_OP_MULT) || (op_i == MULDIV_OP_MULTU);
        is_div_op_s = (op_i == MULDIV_OP_DIV) || (op_i == MULDIV_OP_DIVU);
`ifdef MIPS_MULDIV_FAST_MULT_EN
        core_load_s = accept_s & is_div_op_s & ~b_zero_s;
`else
        core_load_s = accept_s & (is_mul_op_s | (is_div_op_s & ~b_zero_s));
`endif
        core_step_s = (state_q == MULDIV_ST_MUL) || (state_q == MULDIV_ST_DIV);
    end

    mips_cpu_muldiv_core_iter #(
        .WIDTH (WIDTH)
    ) u_core_iter (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .en_i       (clk_enable_i),
        .load_i     (core_load_s),
        .mode_div_i (is_div_op_s),
        .step_i     (core_step_s),
        .a_mag_i    (a_mag_s),
        .b_mag_i    (b_mag_s),
        .acc_hi_o   (core_hi_s),
        .acc_lo_o   (core_lo_s),
        .last_o     (core_last_s)
    );

    // Sign fix-up of the unsigned iteration result and divide-by-zero values.
    always_comb begin
        prod_s     = {core_hi_s, core_lo_s};
        prod_fix_s = prod_neg_q ? (~prod_s + (2*WIDTH)'(1)) : prod_s;
        quo_fix_s  = quo_neg_q ? (~core_lo_s + WIDTH'(1)) : core_lo_s;
        rem_fix_s  = rem_neg_q ? (~core_hi_s + WIDTH'(1)) : core_hi_s;
        if (div0_q) begin
            hi_d = a_raw_q;
            lo_d = DIV0_LO;
        end else if (is_div_q) begin
            hi_d = rem_fix_s;
            lo_d = quo_fix_s;
        end else begin
            hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
            lo_d = prod_fix_s[WIDTH-1:0];
        end
    end

    // Control FSM with HI/LO, busy and done registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= MULDIV_ST_IDLE;
            hi_q       <= {WIDTH{1'b0}};
            lo_q       <= {WIDTH{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            is_div_q   <= 1'b0;
            div0_q     <= 1'b0;
            prod_neg_q <= 1'b0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            a_raw_q    <= {WIDTH{1'b0}};
        end else if (clk_enable_i) begin
            done_q <= 1'b0;
            case (state_q)
                MULDIV_ST_IDLE: begin
                    if (accept_s) begin
                        case (op_i)
                            MULDIV_OP_MTHI: hi_q <= op_a_i;
                            MULDIV_OP_MTLO: lo_q <= op_a_i;
                            MULDIV_OP_MULT, MULDIV_OP_MULTU: begin
`ifdef MIPS_MULDIV_FAST_MULT_EN
                                hi_q   <= fast_prod_s[2*WIDTH-1:WIDTH];
                                lo_q   <= fast_prod_s[WIDTH-1:0];
                                done_q <= 1'b1;
`else
                                state_q    <= MULDIV_ST_MUL;
                                busy_q     <= 1'b1;
                                is_div_q   <= 1'b0;
                                div0_q     <= 1'b0;
                                prod_neg_q <= a_neg_s ^ b_neg_s;
`endif
                            end
                            MULDIV_OP_DIV, MULDIV_OP_DIVU: begin
                                // Divide by zero skips iteration entirely.
                                state_q   <= b_zero_s ? MULDIV_ST_FIX : MULDIV_ST_DIV;
                                busy_q    <= 1'b1;
                                is_div_q  <= 1'b1;
                                div0_q    <= b_zero_s;
                                quo_neg_q <= a_neg_s ^ b_neg_s;
                                rem_neg_q <= a_neg_s;
                                a_raw_q   <= op_a_i;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                MULDIV_ST_MUL, MULDIV_ST_DIV: begin
                    if (core_last_s) begin
                        state_q <= MULDIV_ST_FIX;
                    end
                end
                MULDIV_ST_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= MULDIV_ST_IDLE;
                end
                default: begin
                    state_q <= MULDIV_ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign op_ready_o = ~busy_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_mips_cpu_muldiv_unit
//   Directed self-checking bench for mips_cpu_muldiv_unit (WIDTH = 32).
//   Expected HI/LO pairs are queued when an operation is issued and popped
//   when done is seen.
// -----------------------------------------------------------------------------
module tb_mips_cpu_muldiv_unit;
    import mips_cpu_pkg::*;

`ifdef MIPS_MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        clk_enable_i;
    logic        op_valid_i;
    logic        op_ready_o;
    muldiv_op_t  op_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] sb[$];
    logic [31:0] arch_hi = 32'h0;
    logic [31:0] arch_lo = 32'h0;

    mips_cpu_muldiv_unit #(
        .WIDTH   (32),
        .DIV0_LO ('1)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .clk_enable_i (clk_enable_i),
        .op_valid_i   (op_valid_i),
        .op_ready_o   (op_ready_o),
        .op_i         (op_i),
        .op_a_i       (op_a_i),
        .op_b_i       (op_b_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo);
        sb.push_back({ehi, elo});
        op_i       = o;
        op_a_i     = a;
        op_b_i     = b;
        op_valid_i = 1'b1;
    endtask

    // Called just after the accepting edge; waits (bounded) for done.
    task automatic wait_done(input string tag, input int elat, input int stall_at, input int stall_len);
        int          lat;
        logic [63:0] exp;
        lat = 0;
        while (done_o !== 1'b1 && lat < 100) begin
            if (lat == stall_at) clk_enable_i = 1'b0;
            if (lat == stall_at + stall_len) clk_enable_i = 1'b1;
            check({tag, "_busy_ready"}, {62'd0, busy_o, op_ready_o}, 64'd2);
            check({tag, "_hilo_hold"}, {hi_o, lo_o}, {arch_hi, arch_lo});
            tick();
            lat++;
        end
        clk_enable_i = 1'b1;
        check({tag, "_latency"}, 64'(lat), 64'(elat));
        check({tag, "_busy_end"}, {62'd0, busy_o, op_ready_o}, 64'd1);
        exp = sb.pop_front();
        check({tag, "_hilo"}, {hi_o, lo_o}, exp);
        arch_hi = exp[63:32];
        arch_lo = exp[31:0];
    endtask

    task automatic run_op(input string tag, input muldiv_op_t o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int elat, input int stall_at, input int stall_len);
        issue(o, a, b, ehi, elo);
        tick();
        op_valid_i = 1'b0;
        op_i       = MULDIV_OP_NONE;
        op_a_i     = $urandom;
        op_b_i     = $urandom;
        wait_done(tag, elat, stall_at, stall_len);
    endtask

    task automatic move_to(input string tag, input muldiv_op_t o, input logic [31:0] a);
        op_i       = o;
        op_a_i     = a;
        op_valid_i = 1'b1;
        tick();
        op_valid_i = 1'b0;
        op_i       = MULDIV_OP_NONE;
        if (o == MULDIV_OP_MTHI) arch_hi = a;
        if (o == MULDIV_OP_MTLO) arch_lo = a;
        check({tag, "_hilo"}, {hi_o, lo_o}, {arch_hi, arch_lo});
        check({tag, "_busy_done"}, {62'd0, busy_o, done_o}, 64'd0);
    endtask

    initial begin
        int saw_done;
        reset_i      = 1'b1;
        clk_enable_i = 1'b1;
        op_valid_i   = 1'b0;
        op_i         = MULDIV_OP_NONE;
        op_a_i       = 32'h0;
        op_b_i       = 32'h0;
        tick();
        tick();
        reset_i = 1'b0;
        check("reset_hilo", {hi_o, lo_o}, 64'd0);
        check("reset_busy_done_ready", {61'd0, busy_o, done_o, op_ready_o}, 64'd1);

        // Main multiply/divide patterns, issued back to back.
        run_op("multu_max", MULDIV_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT, -1, 0);
        run_op("mult_neg",  MULDIV_OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, MUL_LAT, -1, 0);
        run_op("div_neg",   MULDIV_OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT, -1, 0);
        run_op("div_negb",  MULDIV_OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_LAT, -1, 0);
        run_op("mult_nn",   MULDIV_OP_MULT,  32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E, MUL_LAT, -1, 0);
        run_op("mult_min",  MULDIV_OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MUL_LAT, -1, 0);
        run_op("divu_zero", MULDIV_OP_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1, -1, 0);
        run_op("div_zero",  MULDIV_OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1, -1, 0);
        run_op("div_ovf",   MULDIV_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_LAT, -1, 0);
        run_op("divu_big",  MULDIV_OP_DIVU,  32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 32'h0000FFFF, DIV_LAT, -1, 0);

        // Clock enable held low for five cycles mid-divide.
        run_op("divu_stall", MULDIV_OP_DIVU, 32'd1000, 32'd7, 32'h00000006, 32'h0000008E, DIV_LAT + 5, 10, 5);

        // Moves to HI/LO and a NONE op.
        move_to("mthi", MULDIV_OP_MTHI, 32'h12345678);
        move_to("mtlo", MULDIV_OP_MTLO, 32'h9ABCDEF0);
        move_to("none", MULDIV_OP_NONE, 32'h55555555);

        // Request while clock enable is low is not sampled.
        clk_enable_i = 1'b0;
        op_i         = MULDIV_OP_MTHI;
        op_a_i       = 32'hDEADBEEF;
        op_valid_i   = 1'b1;
        tick();
        op_valid_i   = 1'b0;
        clk_enable_i = 1'b1;
        tick();
        check("en_low_mthi", {hi_o, lo_o}, {arch_hi, arch_lo});

        // DIVU presented while MULTU busy: held by the core, taken at op_ready.
        issue(MULDIV_OP_MULTU, 32'd6, 32'd7, 32'h0, 32'd42);
        tick();
        op_i   = MULDIV_OP_DIVU;
        op_a_i = 32'd100;
        op_b_i = 32'd9;
        sb.push_back({32'd1, 32'd11});
        wait_done("held_multu", MUL_LAT, -1, 0);
        tick();
        op_valid_i = 1'b0;
        op_i       = MULDIV_OP_NONE;
        op_a_i     = $urandom;
        op_b_i     = $urandom;
        wait_done("held_divu", DIV_LAT, -1, 0);

        // Reset mid-multiply discards the operation.
        op_i       = MULDIV_OP_MULTU;
        op_a_i     = 32'd5;
        op_b_i     = 32'd5;
        op_valid_i = 1'b1;
        tick();
        op_valid_i = 1'b0;
        op_i       = MULDIV_OP_NONE;
        repeat (5) tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        arch_hi = 32'h0;
        arch_lo = 32'h0;
        check("midreset_hilo", {hi_o, lo_o}, 64'd0);
        check("midreset_busy_done_ready", {61'd0, busy_o, done_o, op_ready_o}, 64'd1);
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done_o !== 1'b0 || busy_o !== 1'b0) saw_done++;
        end
        check("midreset_no_done", 64'(saw_done), 64'd0);

        run_op("multu_small", MULDIV_OP_MULTU, 32'd3, 32'd5, 32'h0, 32'h0000000F, MUL_LAT, -1, 0);
        tick();
        check("done_pulse_end", {63'd0, done_o}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
